// File: rtl/ctx_save_if.sv
// Context save/restore bus: requests, register-file ports, context RAM port and status.
// master = ctx_save_ctrl side, slave = pipeline / register file / RAM side.
interface ctx_save_if #(
    parameter int LVL_W = 2
);
    logic             save_req;
    logic             restore_req;
    logic [4:0]       rf_ra;
    logic [31:0]      rf_a;
    logic             rf_we;
    logic [4:0]       rf_rw;
    logic [31:0]      rf_w;
    logic             mem_we;
    logic             mem_re;
    logic [LVL_W+4:0] mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic             busy;
    logic             done;
    logic             err;
    logic [LVL_W:0]   depth;

    modport master (
        input  save_req, restore_req, rf_a, mem_rdata,
        output rf_ra, rf_we, rf_rw, rf_w, mem_we, mem_re, mem_addr, mem_wdata,
        output busy, done, err, depth
    );

    modport slave (
        output save_req, restore_req, rf_a, mem_rdata,
        input  rf_ra, rf_we, rf_rw, rf_w, mem_we, mem_re, mem_addr, mem_wdata,
        input  busy, done, err, depth
    );
endinterface

// File: rtl/ctx_save_ctrl.sv
// Nested interrupt context save/restore sequencer between register file and context RAM.
// Optional macro CTX_SKIP_K_EN: skip registers 26/27 (k0/k1) in both directions.
module ctx_save_ctrl #(
    parameter int LVL_W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    ctx_save_if.master   bus
);
    // state   | meaning
    // IDLE    | accept save/restore requests, no strobes
    // SAVE    | copy r[idx] to frame at current depth, one register per cycle
    // RESTORE | read frame word idx, write previous word to register file

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2
    } state_t;

    localparam logic [LVL_W:0] LEVELS_C = {1'b1, {LVL_W{1'b0}}};

    state_t         state_q, state_d;
    logic [4:0]     idx_q, idx_d;
    logic [LVL_W:0] depth_q, depth_d;
    logic           rd_fin_q, rd_fin_d;
    logic           wr_v_q, wr_v_d;
    logic [4:0]     wr_idx_q, wr_idx_d;
    logic           err_q, err_d;

    logic             done_c;
    logic [4:0]       rf_ra_c;
    logic             rf_we_c;
    logic [4:0]       rf_rw_c;
    logic [31:0]      rf_w_c;
    logic             mem_we_c;
    logic             mem_re_c;
    logic [LVL_W+4:0] mem_addr_c;
    logic [31:0]      mem_wdata_c;

    function automatic logic [4:0] next_idx(input logic [4:0] k);
`ifdef CTX_SKIP_K_EN
        return (k == 5'd25) ? 5'd28 : k + 5'd1;
`else
        return k + 5'd1;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= 5'd0;
            depth_q  <= '0;
            rd_fin_q <= 1'b0;
            wr_v_q   <= 1'b0;
            wr_idx_q <= 5'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            depth_q  <= depth_d;
            rd_fin_q <= rd_fin_d;
            wr_v_q   <= wr_v_d;
            wr_idx_q <= wr_idx_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        depth_d     = depth_q;
        rd_fin_d    = 1'b0;
        wr_v_d      = 1'b0;
        wr_idx_d    = 5'd0;
        err_d       = 1'b0;
        done_c      = 1'b0;
        rf_ra_c     = 5'd0;
        rf_we_c     = 1'b0;
        rf_rw_c     = 5'd0;
        rf_w_c      = 32'd0;
        mem_we_c    = 1'b0;
        mem_re_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = 32'd0;

        unique case (state_q)
            IDLE: begin
                idx_d = 5'd0;
                // save has priority; a restore arriving with it is dropped
                if (bus.save_req) begin
                    if (depth_q != LEVELS_C) begin
                        state_d = SAVE;
                        idx_d   = 5'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.restore_req) begin
                    if (depth_q != '0) begin
                        state_d = RESTORE;
                        idx_d   = 5'd1;
                        depth_d = depth_q - 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            SAVE: begin
                rf_ra_c     = idx_q;
                mem_we_c    = 1'b1;
                mem_addr_c  = {depth_q[LVL_W-1:0], idx_q};
                mem_wdata_c = bus.rf_a;
                if (idx_q == 5'd31) begin
                    done_c  = 1'b1;
                    depth_d = depth_q + 1'b1;
                    idx_d   = 5'd0;
                    state_d = IDLE;
                end else begin
                    idx_d = next_idx(idx_q);
                end
            end

            RESTORE: begin
                // write side trails the read side by one cycle (RAM latency)
                rf_we_c = wr_v_q;
                rf_rw_c = wr_idx_q;
                rf_w_c  = wr_v_q ? bus.mem_rdata : 32'd0;
                if (!rd_fin_q) begin
                    mem_re_c   = 1'b1;
                    mem_addr_c = {depth_q[LVL_W-1:0], idx_q};
                    wr_v_d     = 1'b1;
                    wr_idx_d   = idx_q;
                    if (idx_q == 5'd31) begin
                        rd_fin_d = 1'b1;
                    end else begin
                        idx_d = next_idx(idx_q);
                    end
                end else begin
                    done_c  = 1'b1;
                    idx_d   = 5'd0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                idx_d   = 5'd0;
            end
        endcase
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_c;
    assign bus.err       = err_q;
    assign bus.depth     = depth_q;
    assign bus.rf_ra     = rf_ra_c;
    assign bus.rf_we     = rf_we_c;
    assign bus.rf_rw     = rf_rw_c;
    assign bus.rf_w      = rf_w_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_re    = mem_re_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
endmodule

// File: tb/tb_ctx_save_ctrl.sv
// Bench for ctx_save_ctrl: table of directed ops, hand-written reset sequence, random ops vs a frame-stack model.
module tb_ctx_save_ctrl;
    localparam int LVL_W  = 2;
    localparam int LEVELS = 4;
`ifdef CTX_SKIP_K_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam int NS   = SKIP ? 29 : 31;
    localparam int NR   = NS + 1;
    localparam int NCYC = 36;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ctx_save_if #(.LVL_W(LVL_W)) bus ();
    ctx_save_ctrl #(.LVL_W(LVL_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;

    // register-file read source and context RAM
    bit          pattern = 1'b1;
    logic [31:0] src [32];
    logic [31:0] ram [128];
    logic [31:0] rdata = 32'd0;

    assign bus.rf_a      = pattern ? (32'hA5A50000 + {27'd0, bus.rf_ra}) : src[bus.rf_ra];
    assign bus.mem_rdata = rdata;

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) rdata <= ram[bus.mem_addr];
    end

    // reference model: stack of saved frames
    logic [31:0] store [LEVELS][32];
    int          mdepth = 0;

    // per-op observation logs
    logic [31:0] mw_addr_q[$], mw_data_q[$], rd_addr_q[$], rw_idx_q[$], rw_data_q[$];
    int busy_cnt, done_cnt, done_at, err_cnt, err_at, both_cnt, bad_rw;
    int rst_busy, rst_strobe, rst_depth;

    typedef struct {
        bit s;
        bit r;
        int inj;
        bit inj_s;
        bit exp_err;
        int exp_depth;
        int exp_busy;
    } vec_t;
    vec_t vecs [15];

    function automatic bit skipped(input int k);
        return SKIP && (k == 26 || k == 27);
    endfunction

    task automatic expect_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_q(input string name, input logic [31:0] a[$], input logic [31:0] e[$]);
        int bad;
        bad = -1;
        checks++;
        if (a.size() != e.size()) begin
            failures++;
            $display("FAIL %s count actual=%0d required=%0d", name, a.size(), e.size());
        end else begin
            foreach (a[i]) if (bad < 0 && a[i] !== e[i]) bad = i;
            if (bad >= 0) begin
                failures++;
                $display("FAIL %s entry %0d actual=0x%0h required=0x%0h", name, bad, a[bad], e[bad]);
            end
        end
    endtask

    task automatic run_op(input bit s, input bit r, input int inj_c, input bit inj_s, input int rst_c);
        mw_addr_q.delete(); mw_data_q.delete(); rd_addr_q.delete();
        rw_idx_q.delete();  rw_data_q.delete();
        busy_cnt = 0; done_cnt = 0; done_at = 0; err_cnt = 0; err_at = 0;
        both_cnt = 0; bad_rw = 0; rst_busy = -1; rst_strobe = -1; rst_depth = -1;
        @(negedge clk);
        bus.save_req    = s;
        bus.restore_req = r;
        for (int c = 1; c <= NCYC; c++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin done_cnt++; done_at = c; end
            if (bus.err) begin err_cnt++; err_at = c; end
            if (bus.done && bus.err) both_cnt++;
            if (bus.mem_we) begin
                mw_addr_q.push_back({25'd0, bus.mem_addr});
                mw_data_q.push_back(bus.mem_wdata);
            end
            if (bus.mem_re) rd_addr_q.push_back({25'd0, bus.mem_addr});
            if (bus.rf_we) begin
                if (bus.rf_rw == 5'd0) bad_rw++;
                rw_idx_q.push_back({27'd0, bus.rf_rw});
                rw_data_q.push_back(bus.rf_w);
            end
            if (c == 1) begin bus.save_req = 1'b0; bus.restore_req = 1'b0; end
            if (inj_c > 0 && c == inj_c) begin
                if (inj_s) bus.save_req = 1'b1; else bus.restore_req = 1'b1;
            end
            if (inj_c > 0 && c == inj_c + 1) begin bus.save_req = 1'b0; bus.restore_req = 1'b0; end
            if (rst_c > 0 && c == rst_c) rst_n = 1'b0;
            if (rst_c > 0 && c == rst_c + 1) begin
                rst_busy   = int'(bus.busy);
                rst_strobe = int'(bus.mem_we | bus.mem_re | bus.rf_we | bus.done | bus.err);
                rst_depth  = int'(bus.depth);
                rst_n      = 1'b1;
            end
        end
    endtask

    // runs one op and checks every observation against the frame-stack model
    task automatic check_op(input bit s, input bit r, input int inj_c, input bit inj_s);
        logic [31:0] ea[$], ed[$], ei[$];
        bit e;
        int n;
        e = s ? (mdepth == LEVELS) : (r && mdepth == 0);
        run_op(s, r, inj_c, inj_s, 0);
        if (e) begin
            expect_eq("err_count", err_cnt, 1);
            expect_eq("err_cycle", err_at, 1);
            expect_eq("err_busy", busy_cnt, 0);
            expect_eq("err_strobes", mw_addr_q.size() + rd_addr_q.size() + rw_idx_q.size(), 0);
        end else if (s) begin
            for (int k = 1; k < 32; k++) begin
                if (!skipped(k)) begin
                    ea.push_back(32'(mdepth * 32 + k));
                    ed.push_back(pattern ? 32'hA5A50000 + 32'(k) : src[k]);
                    store[mdepth][k] = pattern ? 32'hA5A50000 + 32'(k) : src[k];
                end
            end
            mdepth++;
            check_q("save_addr", mw_addr_q, ea);
            check_q("save_data", mw_data_q, ed);
            expect_eq("save_busy", busy_cnt, NS);
            expect_eq("save_done_cycle", done_at, NS);
            expect_eq("save_done_count", done_cnt, 1);
            expect_eq("save_err", err_cnt, 0);
        end else if (r) begin
            mdepth--;
            for (int k = 1; k < 32; k++) begin
                if (!skipped(k)) begin
                    ea.push_back(32'(mdepth * 32 + k));
                    ei.push_back(32'(k));
                    ed.push_back(store[mdepth][k]);
                end
            end
            check_q("restore_rd_addr", rd_addr_q, ea);
            check_q("restore_rf_idx", rw_idx_q, ei);
            check_q("restore_rf_data", rw_data_q, ed);
            expect_eq("restore_busy", busy_cnt, NR);
            expect_eq("restore_done_cycle", done_at, NR);
            expect_eq("restore_err", err_cnt, 0);
        end else begin
            n = busy_cnt + done_cnt + err_cnt;
            expect_eq("idle_quiet", n, 0);
        end
        expect_eq("depth", bus.depth, mdepth);
        expect_eq("done_err_overlap", both_cnt, 0);
        expect_eq("rf_rw_zero", bad_rw, 0);
    endtask

    initial begin
        bus.save_req    = 1'b0;
        bus.restore_req = 1'b0;
        for (int k = 0; k < 32; k++) src[k] = 32'd0;

        //           s  r  inj injs err depth busy
        vecs[0]  = '{0, 1, 0,  0,   1,  0,    0};
        vecs[1]  = '{1, 0, 0,  0,   0,  1,    NS};
        vecs[2]  = '{0, 1, 0,  0,   0,  0,    NR};
        vecs[3]  = '{1, 0, 0,  0,   0,  1,    NS};
        vecs[4]  = '{1, 1, 5,  1,   0,  2,    NS};
        vecs[5]  = '{1, 0, 12, 0,   0,  3,    NS};
        vecs[6]  = '{1, 0, 0,  0,   0,  4,    NS};
        vecs[7]  = '{1, 0, 0,  0,   1,  4,    0};
        vecs[8]  = '{1, 1, 0,  0,   1,  4,    0};
        vecs[9]  = '{0, 1, 0,  0,   0,  3,    NR};
        vecs[10] = '{0, 1, 20, 1,   0,  2,    NR};
        vecs[11] = '{0, 1, 0,  0,   0,  1,    NR};
        vecs[12] = '{0, 1, 0,  0,   0,  0,    NR};
        vecs[13] = '{0, 1, 0,  0,   1,  0,    0};
        vecs[14] = '{0, 0, 0,  0,   0,  0,    0};

        repeat (3) @(negedge clk);
        expect_eq("reset_busy", bus.busy, 0);
        expect_eq("reset_depth", bus.depth, 0);
        expect_eq("reset_strobes", {bus.mem_we, bus.mem_re, bus.rf_we, bus.done, bus.err}, 0);
        expect_eq("reset_rf_ra", bus.rf_ra, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            pattern = (i < 3);
            for (int k = 1; k < 32; k++) src[k] = $urandom;
            check_op(vecs[i].s, vecs[i].r, vecs[i].inj, vecs[i].inj_s);
            expect_eq($sformatf("vec%0d_err", i), err_cnt != 0, vecs[i].exp_err);
            expect_eq($sformatf("vec%0d_depth", i), bus.depth, vecs[i].exp_depth);
            expect_eq($sformatf("vec%0d_busy", i), busy_cnt, vecs[i].exp_busy);
            if (i == 1) begin
                expect_eq("save_first_addr", mw_addr_q[0], 32'h01);
                expect_eq("save_first_data", mw_data_q[0], 32'hA5A50001);
            end
            if (i == 4) expect_eq("save_base_frame1", mw_addr_q[0], 32'h21);
        end

        // reset in the middle of a save, then a fresh save starts at idx 1
        pattern = 1'b1;
        run_op(1'b1, 1'b0, 0, 1'b0, 10);
        mdepth = 0;
        expect_eq("midsave_writes", mw_addr_q.size(), 10);
        expect_eq("midsave_busy", rst_busy, 0);
        expect_eq("midsave_strobes", rst_strobe, 0);
        expect_eq("midsave_depth", rst_depth, 0);
        expect_eq("midsave_done", done_cnt, 0);
        check_op(1'b1, 1'b0, 0, 1'b0);
        expect_eq("resave_first_addr", mw_addr_q[0], 32'h01);

        // reset in the middle of a restore
        run_op(1'b0, 1'b1, 0, 1'b0, 15);
        mdepth = 0;
        expect_eq("midrestore_busy", rst_busy, 0);
        expect_eq("midrestore_strobes", rst_strobe, 0);
        expect_eq("midrestore_depth", rst_depth, 0);

        pattern = 1'b0;
        for (int n = 0; n < 160; n++) begin
            int pick;
            bit s, r, busy_op;
            int inj;
            for (int k = 1; k < 32; k++) src[k] = $urandom;
            pick = $urandom_range(0, 9);
            s = (pick <= 3) || (pick == 7);
            r = (pick >= 4 && pick <= 7);
            if (pick == 9) begin
                run_op(mdepth < LEVELS, mdepth == LEVELS, 0, 1'b0, $urandom_range(2, 20));
                mdepth = 0;
                expect_eq("rnd_rst_busy", rst_busy, 0);
                expect_eq("rnd_rst_depth", rst_depth, 0);
            end else begin
                busy_op = s ? (mdepth < LEVELS) : (r && mdepth > 0);
                inj = (busy_op && $urandom_range(0, 2) == 0) ? $urandom_range(2, 29) : 0;
                check_op(s, r, inj, $urandom_range(0, 1) == 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ctx_save_ctrl.md
CTX_SAVE_CTRL -- requirements
Module: ctx_save_ctrl

Interface
REQ-001 SHALL have parameter LVL_W, default 2, meaning log2 of the number of nested context frames (LEVELS = 2^LVL_W).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port save_req  input  1  single-cycle pulse requesting a context save (interrupt entry).
REQ-005 SHALL have port restore_req  input  1  single-cycle pulse requesting a context restore (eret).
REQ-006 SHALL have ports rf_ra  output  5  register-file read address; rf_a  input  32  combinational read data.
REQ-007 SHALL have ports rf_we  output  1; rf_rw  output  5; rf_w  output  32, forming the register-file write port, sampled by the register file on negedge.
REQ-008 SHALL have ports mem_we  output  1; mem_re  output  1; mem_addr  output  LVL_W+5; mem_wdata  output  32; mem_rdata  input  32, forming the context RAM interface, with read data valid one cycle after mem_re.
REQ-009 SHALL have ports busy  output  1 (stall to pipeline); done  output  1 (pulse); err  output  1 (pulse); depth  output  LVL_W+1 (saved frames).

Function
REQ-010 SHALL implement FSM states IDLE, SAVE, RESTORE; idx counter 5 bits; depth counter LVL_W+1 bits.
REQ-011 In IDLE: busy=0; rf_we=mem_we=mem_re=0; rf_ra=0; requests accepted only in IDLE and ignored otherwise.
REQ-012 save_req with depth<LEVELS: IDLE->SAVE, idx=1, busy=1 from next cycle.
REQ-013 In SAVE, cycle with idx=k: rf_ra=k, mem_we=1, mem_addr={depth[LVL_W-1:0],k}, mem_wdata=rf_a; idx increments.
REQ-014 SAVE after k=31: depth+1, done=1 for one cycle, ->IDLE; busy high for 31 cycles total.
REQ-015 restore_req with depth>0: IDLE->RESTORE, depth-1 at entry; frame = new depth.
REQ-016 RESTORE pipelined: cycle j (j=1..31) mem_re=1, mem_addr={frame,j}; cycle j+1 rf_we=1, rf_rw=j, rf_w=mem_rdata; 32 busy cycles; done pulses on the last write cycle, then ->IDLE.
REQ-017 save_req and restore_req in the same IDLE cycle: save wins; restore dropped.
REQ-018 save_req at depth==LEVELS or restore_req at depth==0: err=1 one cycle, no state change, no strobes.
REQ-019 rf_rw SHALL never be 0 while rf_we=1; r0 is never saved or restored.
REQ-020 done and err SHALL never assert in the same cycle.

Reset
REQ-021 rst_n=0 at posedge: state=IDLE, idx=0, depth=0, all outputs 0, including mid-SAVE/RESTORE; in-flight frame abandoned, no further strobes.
REQ-022 Reset SHALL take priority over simultaneous requests.

Configuration
REQ-023 Macro CTX_SKIP_K_EN: defined -> registers 26, 27 (k0/k1) skipped in SAVE and RESTORE (idx jumps 25->28, no strobes for them; SAVE 29 busy cycles, RESTORE 30); undefined -> all 31 registers handled as above.

Verification
REQ-024 Reset, rf_a=0xA5A50000+rf_ra, pulse save_req -> 31 mem_we writes addr 0x01..0x1F, data 0xA5A50001..0xA5A5001F; done at cycle 31; depth=1.
REQ-025 After REQ-024, pulse restore_req, RAM returns stored data -> rf_we writes r1..r31 with same data, done after 32 cycles, depth=0.
REQ-026 Four saves (LVL_W=2) then a fifth save_req -> err pulse, depth stays 4, no mem_we; restore_req at depth 0 -> err pulse.
REQ-027 save_req and restore_req together at depth=1 -> save executes (addr base 0x20), depth=2; save_req during busy ignored.
REQ-028 rst_n low at SAVE idx=10 -> next cycle busy=0, mem_we=0, depth=0; new save_req restarts at idx=1.
REQ-029 CTX_SKIP_K_EN defined -> save emits 29 writes, none at addr 26/27, done at cycle 29.
